// File: rtl/and1_gate.sv
// rtl/and1_gate.sv - bitwise AND with registered copy, rise pulse and optional high-cycle counter
// Optional statistics counter is enabled by defining AND1_GATE_STATS_EN.
module and1_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] s_rise,
  output logic             all_hi,
  output logic [CNT_W-1:0] hi_cnt
);

  assign s      = a & b;
  assign all_hi = &s;

  // Rise is judged against the previous registered value, so the pulse lands with s_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      s_rise <= '0;
    end else begin
      s_q    <= s;
      s_rise <= s & ~s_q;
    end
  end

`ifdef AND1_GATE_STATS_EN
  logic [CNT_W-1:0] cnt;

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (all_hi && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hi_cnt = cnt;
`else
  assign hi_cnt = '0;
`endif

endmodule

// File: tb/tb_and1_gate.sv
// tb/tb_and1_gate.sv - directed self-checking bench for and1_gate (WIDTH=1/CNT_W=3 and WIDTH=4)
module tb_and1_gate;

`ifdef AND1_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1, s1, s_q1, s_rise1;
  logic       all_hi1;
  logic [2:0] hi_cnt1;
  logic [3:0] a4, b4, s4, s_q4, s_rise4;
  logic       all_hi4;
  logic [15:0] hi_cnt4;

  int passed = 0;
  int total  = 0;

  and1_gate #(.WIDTH(1), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s1), .s_q(s_q1),
    .s_rise(s_rise1), .all_hi(all_hi1), .hi_cnt(hi_cnt1)
  );

  and1_gate #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .s(s4), .s_q(s_q4),
    .s_rise(s_rise4), .all_hi(all_hi4), .hi_cnt(hi_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  initial begin
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_q1",    32'(s_q1),    32'd0);
    chk("rst_s_rise1", 32'(s_rise1), 32'd0);
    chk("rst_hi_cnt1", 32'(hi_cnt1), 32'd0);
    chk("rst_s_q4",    32'(s_q4),    32'd0);
    a1 = 1'b1; b1 = 1'b1;
    #1;
    chk("rst_s1_live",   32'(s1),      32'd1);
    chk("rst_all_hi1",   32'(all_hi1), 32'd1);
    chk("rst_s_q1_held", 32'(s_q1),    32'd0);
    @(negedge clk);
    chk("rst_s_q1_edge", 32'(s_q1),    32'd0);
    chk("rst_cnt1_edge", 32'(hi_cnt1), 32'd0);

    // truth table 00
    rst_n = 1'b1; a1 = 1'b0; b1 = 1'b0;
    #1 chk("tt00_s", 32'(s1), 32'd0);
    @(negedge clk);
    chk("tt00_s_q",    32'(s_q1),    32'd0);
    chk("tt00_s_rise", 32'(s_rise1), 32'd0);
    a1 = 1'b0; b1 = 1'b1;
    #1 chk("tt01_s", 32'(s1), 32'd0);
    @(negedge clk);
    chk("tt01_s_q", 32'(s_q1), 32'd0);
    a1 = 1'b1; b1 = 1'b0;
    #1 chk("tt10_s", 32'(s1), 32'd0);
    @(negedge clk);
    chk("tt10_s_q", 32'(s_q1), 32'd0);
    a1 = 1'b1; b1 = 1'b1;
    #1;
    chk("tt11_s",       32'(s1),      32'd1);
    chk("tt11_all_hi",  32'(all_hi1), 32'd1);
    chk("tt11_latency", 32'(s_q1),    32'd0);
    @(negedge clk);
    chk("tt11_s_q",    32'(s_q1),    32'd1);
    chk("tt11_s_rise", 32'(s_rise1), 32'd1);
    chk("tt11_cnt",    32'(hi_cnt1), STATS ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("hold_s_rise", 32'(s_rise1), 32'd0);
    chk("hold_cnt",    32'(hi_cnt1), STATS ? 32'd2 : 32'd0);

    // falling edge gives no pulse
    b1 = 1'b0;
    @(negedge clk);
    chk("fall_s_q",    32'(s_q1),    32'd0);
    chk("fall_s_rise", 32'(s_rise1), 32'd0);
    chk("fall_cnt",    32'(hi_cnt1), STATS ? 32'd2 : 32'd0);
    b1 = 1'b1;
    @(negedge clk);
    chk("rise_s_q",    32'(s_q1),    32'd1);
    chk("rise_s_rise", 32'(s_rise1), 32'd1);
    @(negedge clk);
    chk("rise_once",   32'(s_rise1), 32'd0);
    chk("rise_cnt",    32'(hi_cnt1), STATS ? 32'd4 : 32'd0);

    // glitch between edges is invisible to the registers
    b1 = 1'b0;
    #2 b1 = 1'b1;
    @(negedge clk);
    chk("glitch_s_q",    32'(s_q1),    32'd1);
    chk("glitch_s_rise", 32'(s_rise1), 32'd0);
    chk("glitch_cnt",    32'(hi_cnt1), STATS ? 32'd5 : 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("sat_reach", 32'(hi_cnt1), STATS ? 32'd7 : 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("sat_hold",  32'(hi_cnt1), STATS ? 32'd7 : 32'd0);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_q",    32'(s_q1),    32'd0);
    chk("arst_s_rise", 32'(s_rise1), 32'd0);
    chk("arst_cnt",    32'(hi_cnt1), 32'd0);
    chk("arst_s",      32'(s1),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_q",    32'(s_q1),    32'd1);
    chk("post_rst_s_rise", 32'(s_rise1), 32'd1);
    chk("post_rst_cnt",    32'(hi_cnt1), STATS ? 32'd1 : 32'd0);

    // WIDTH=4
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("w4_s",      32'(s4),      32'h8);
    chk("w4_all_hi", 32'(all_hi4), 32'd0);
    @(negedge clk);
    chk("w4_s_q",    32'(s_q4),    32'h8);
    chk("w4_s_rise", 32'(s_rise4), 32'h8);
    chk("w4_cnt0",   32'(hi_cnt4), 32'd0);
    a4 = 4'hF; b4 = 4'hF;
    #1;
    chk("w4f_s",      32'(s4),      32'hF);
    chk("w4f_all_hi", 32'(all_hi4), 32'd1);
    @(negedge clk);
    chk("w4f_s_q",    32'(s_q4),    32'hF);
    chk("w4f_s_rise", 32'(s_rise4), 32'h7);
    chk("w4f_cnt",    32'(hi_cnt4), STATS ? 32'd1 : 32'd0);
    a4 = 4'b0011; b4 = 4'hF;
    @(negedge clk);
    chk("w4d_s_q",    32'(s_q4),    32'h3);
    chk("w4d_s_rise", 32'(s_rise4), 32'h0);
    a4 = 4'hF;
    @(negedge clk);
    chk("w4u_s_q",    32'(s_q4),    32'hF);
    chk("w4u_s_rise", 32'(s_rise4), 32'hC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
